// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported unified instruction/data SRAM between the IF stage
// (instruction fetch) and the MEM stage (LDR/STR). A granted access is
// latched, held on the SRAM pins for WAIT_CYCLES cycles, and completed with a
// one-cycle ready pulse to its owner. Read data is captured into a per-owner
// register that holds until the next capture. While any stage waits on its
// access, the combinational freeze output stalls every pipeline register.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   defined   - IF/MEM conflicts go to whichever side was not granted last.
//   undefined - MEM always beats IF, so the older instruction drains first.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   if_req/if_addr             fetch request (level) and PC
//   if_rdata/if_ready          fetched instruction and its completion pulse
//   mem_rd_req/mem_wr_req      load/store requests (level); both set = store
//   mem_addr/mem_wdata         load/store address and store data
//   mem_rdata/mem_ready        load data and load/store completion pulse
//   ram_addr/ram_wdata         SRAM address and write data
//   ram_re/ram_we              SRAM read and write strobes
//   ram_rdata                  SRAM read data, valid on the last access cycle
//   freeze                     pipeline-wide stall
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              freeze
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              own_if_q, own_if_d;     // 1: IF owns the access, 0: MEM
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic mem_any;
  logic grant_if;

  assign mem_any = mem_rd_req | mem_wr_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_if_q, last_if_d;                // 1: last grant went to IF
  // On a conflict the side that was not granted last wins.
  assign grant_if = if_req & (~mem_any | ~last_if_q);
`else
  assign grant_if = if_req & ~mem_any;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_if_d    = own_if_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_if_d   = last_if_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (if_req | mem_any) begin
          own_if_d = grant_if;
          addr_d   = grant_if ? if_addr : mem_addr;
          wdata_d  = grant_if ? '0 : mem_wdata;
          // A simultaneous load and store is treated as a store.
          wr_d     = ~grant_if & mem_wr_req;
          cnt_d    = '0;
          state_d  = S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          last_if_d = grant_if;
`endif
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          if (!wr_q) begin
            if (own_if_q) if_rdata_d  = ram_rdata;
            else          mem_rdata_d = ram_rdata;
          end
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the reset is synchronous and clears the latched datapath as well,
  // so an aborted access leaves nothing on the SRAM pins or rdata outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      own_if_q    <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_if_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_if_q    <= own_if_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_if_q   <= last_if_d;
`endif
    end
  end

  // SRAM pins carry the latched access only while in ACCESS.
  assign ram_addr  = (state_q == S_ACCESS) ? addr_q  : '0;
  assign ram_wdata = (state_q == S_ACCESS) ? wdata_q : '0;
  assign ram_re    = (state_q == S_ACCESS) & ~wr_q;
  assign ram_we    = (state_q == S_ACCESS) &  wr_q;

  // A single owner bit makes the two ready pulses mutually exclusive.
  assign if_ready  = (state_q == S_RESP) &  own_if_q;
  assign mem_ready = (state_q == S_RESP) & ~own_if_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  assign freeze = (if_req & ~if_ready) | (mem_any & ~mem_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed bench for unified_mem_arbiter. The main instance runs with
// WAIT_CYCLES=2 against a small SRAM model; a second instance with
// WAIT_CYCLES=1 covers the simultaneous load+store case. Expected responses
// are queued when a request is driven and compared when a ready pulse
// appears. Expected grant order on conflicts follows ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (WAIT_CYCLES = 2)
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd_req = 1'b0;
  logic        mem_wr_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        freeze;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .freeze(freeze)
  );

  // SRAM model: two fixed instruction words plus a writable data region.
  logic [31:0] mem_arr [0:1023];
  always @(posedge clk) if (ram_we) mem_arr[ram_addr[11:2]] <= ram_wdata;

  function automatic logic [31:0] sram_read(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hE3A0_1005;
      32'h14:  return 32'hE3A0_2007;
      default: return mem_arr[a[11:2]];
    endcase
  endfunction

  assign ram_rdata = ram_re ? sram_read(ram_addr) : 32'h0;

  // Second instance (WAIT_CYCLES = 1)
  logic        b_if_req = 1'b0;
  logic [31:0] b_if_addr = '0;
  logic [31:0] b_if_rdata;
  logic        b_if_ready;
  logic        b_mem_rd_req = 1'b0;
  logic        b_mem_wr_req = 1'b0;
  logic [31:0] b_mem_addr = '0;
  logic [31:0] b_mem_wdata = '0;
  logic [31:0] b_mem_rdata;
  logic        b_mem_ready;
  logic [31:0] b_ram_addr;
  logic [31:0] b_ram_wdata;
  logic        b_ram_re;
  logic        b_ram_we;
  logic [31:0] b_ram_rdata = 32'h0BAD_0BAD;
  logic        b_freeze;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_rd_req(b_mem_rd_req), .mem_wr_req(b_mem_wr_req), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_re(b_ram_re), .ram_we(b_ram_we),
    .ram_rdata(b_ram_rdata), .freeze(b_freeze)
  );

  // Scoreboard
  typedef struct {
    bit          is_if;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_if, input bit chk, input logic [31:0] data);
    exp_t e;
    e.is_if = is_if; e.chk_data = chk; e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input bit got_if, input logic [31:0] got_data);
    exp_t e;
    check("sb_nonempty", 64'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("resp_owner", got_if, e.is_if);
      if (e.chk_data) check("resp_rdata", got_data, e.data);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for a ready pulse, checks it against the scoreboard and
  // drops the finished requester's request.
  task automatic wait_resp();
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      next_cycle();
      #1;
      if (if_ready | mem_ready) begin
        seen = 1'b1;
        check("ready_exclusive", if_ready & mem_ready, 0);
        sb_pop(if_ready, if_ready ? if_rdata : mem_rdata);
        if (if_ready) if_req = 1'b0;
        else begin mem_rd_req = 1'b0; mem_wr_req = 1'b0; end
      end
    end
    check("resp_seen", seen, 1);
  endtask

  task automatic apply_reset();
    next_cycle();
    rst = 1'b1;
    if_req = 1'b0; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  // One uncontended access with cycle-exact checks.
  task automatic do_single(input bit is_if, input bit is_wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
    next_cycle();
    cyc = 0;
    if (is_if) begin if_req = 1'b1; if_addr = addr; end
    else begin
      mem_wr_req = is_wr; mem_rd_req = ~is_wr; mem_addr = addr; mem_wdata = wdata;
    end
    push(is_if, ~is_wr, exp_data);
    #1;
    check("c0_freeze", freeze, 1);
    check("c0_ram_re", ram_re, 0);
    check("c0_ram_we", ram_we, 0);
    for (int c = 1; c <= WC; c++) begin
      next_cycle();
      if (c == 1) begin
        // Mid-access changes must not reach the SRAM.
        if_addr = addr ^ 32'hFFF; mem_addr = addr ^ 32'hFFF; mem_wdata = ~wdata;
      end
      #1;
      check("acc_ram_re", ram_re, !is_wr);
      check("acc_ram_we", ram_we, is_wr);
      check("acc_ram_addr", ram_addr, addr);
      if (is_wr) check("acc_ram_wdata", ram_wdata, wdata);
      check("acc_freeze", freeze, 1);
      check("acc_if_ready", if_ready, 0);
      check("acc_mem_ready", mem_ready, 0);
    end
    next_cycle();
    #1;
    check("resp_if_ready", if_ready, is_if);
    check("resp_mem_ready", mem_ready, !is_if);
    check("resp_ram_re", ram_re, 0);
    check("resp_ram_we", ram_we, 0);
    check("resp_freeze", freeze, 0);
    sb_pop(if_ready, is_if ? if_rdata : mem_rdata);
    if_req = 1'b0; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
    next_cycle();
    #1;
    check("post_if_ready", if_ready, 0);
    check("post_mem_ready", mem_ready, 0);
    if (!is_wr) check("rdata_hold", is_if ? if_rdata : mem_rdata, exp_data);
  endtask

  initial begin
    // Reset state
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check("rst_if_ready", if_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_ram_re", ram_re, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_freeze", freeze, 0);

    // Single fetch, then a store, then a load of the stored word
    do_single(1'b1, 1'b0, 32'h10, 32'h0, 32'hE3A0_1005);
    do_single(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 32'h0);
    do_single(1'b0, 1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF);

    // Conflict: MEM drains first, IF follows
    apply_reset();
    next_cycle();
    cyc = 0;
    if_req = 1'b1; if_addr = 32'h10;
    mem_rd_req = 1'b1; mem_addr = 32'h400;
    push(1'b0, 1'b1, 32'hDEAD_BEEF);
    push(1'b1, 1'b1, 32'hE3A0_1005);
    #1;
    check("cf_freeze0", freeze, 1);
    wait_resp();
    check("cf_mem_cycle", cyc, 3);
    #1;
    check("cf_freeze_if_waiting", freeze, 1);
    wait_resp();
    check("cf_if_cycle", cyc, 7);

    // Back-to-back conflicts: MEM keeps requesting after its first access
    apply_reset();
    next_cycle();
    cyc = 0;
    if_req = 1'b1; if_addr = 32'h10;
    mem_rd_req = 1'b1; mem_addr = 32'h400;
    push(1'b0, 1'b1, 32'hDEAD_BEEF);
    wait_resp();
    check("bb_first_cycle", cyc, 3);
    mem_wr_req = 1'b1; mem_addr = 32'h404; mem_wdata = 32'h1234_5678;
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b1, 1'b1, 32'hE3A0_1005);
    push(1'b0, 1'b0, 32'h0);
`else
    push(1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b1, 32'hE3A0_1005);
`endif
    wait_resp();
    check("bb_second_cycle", cyc, 7);
    wait_resp();
    check("bb_third_cycle", cyc, 11);
    check("sb_drained", sb.size(), 0);

    // Reset during the second ACCESS cycle of a store
    next_cycle();
    cyc = 0;
    mem_wr_req = 1'b1; mem_addr = 32'h500; mem_wdata = 32'hCAFE_F00D;
    next_cycle();
    #1;
    check("ra_we_c1", ram_we, 1);
    next_cycle();
    #1;
    check("ra_we_c2", ram_we, 1);
    rst = 1'b1;
    mem_wr_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    check("ra_we_after", ram_we, 0);
    check("ra_re_after", ram_re, 0);
    check("ra_addr_after", ram_addr, 0);
    check("ra_no_ready", mem_ready, 0);
    next_cycle();
    #1;
    check("ra_no_ready2", mem_ready, 0);
    check("ra_freeze", freeze, 0);
    do_single(1'b1, 1'b0, 32'h14, 32'h0, 32'hE3A0_2007);

    // WAIT_CYCLES=1 instance: load and store together act as a store
    next_cycle();
    b_mem_rd_req = 1'b1; b_mem_wr_req = 1'b1;
    b_mem_addr = 32'h40; b_mem_wdata = 32'h55AA_55AA;
    #1;
    check("w1_freeze", b_freeze, 1);
    next_cycle();
    #1;
    check("w1_ram_we", b_ram_we, 1);
    check("w1_ram_re", b_ram_re, 0);
    check("w1_ram_addr", b_ram_addr, 32'h40);
    check("w1_ram_wdata", b_ram_wdata, 32'h55AA_55AA);
    check("w1_ready_early", b_mem_ready, 0);
    next_cycle();
    #1;
    check("w1_ready", b_mem_ready, 1);
    check("w1_we_off", b_ram_we, 0);
    check("w1_if_ready", b_if_ready, 0);
    b_mem_rd_req = 1'b0; b_mem_wr_req = 1'b0;
    next_cycle();
    #1;
    check("w1_ready_off", b_mem_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
